pipe_skid_stage: RTL and testbench
==================================

Name: pipe_skid_stage

Overview:
- Parametrised pipeline-boundary register with a valid/ready handshake and a 2-entry skid buffer. It generalises the fixed IF/ID register.
- Carries an arbitrary-width payload and supports flush, stall and back-pressure without combinational ready paths.
- Instantiated at IF/ID, ID/EX and EX/MEM boundaries.
- Inserts a configurable bubble word when empty and counts squashed entries for performance debug.

Parameters:
- DATA_W, 64, payload width in bits (e.g. {pc_plus_4, instr}).
- BUBBLE_DATA, '0, value driven on out_data whenever out_valid=0.
- SKID_EN, 1, 1 = 2-entry skid buffer (in_ready registered); 0 = single entry, in_ready = !full || out_ready.
- CNT_W, 16, width of the saturating flush-drop counter.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream payload valid
- in_data  in  DATA_W  upstream payload
- in_ready  out  1  stage can accept this cycle
- out_valid  out  1  downstream payload valid
- out_data  out  DATA_W  downstream payload (BUBBLE_DATA when !out_valid)
- out_ready  in  1  downstream accepts this cycle
- flush  in  1  squash all held entries
- stall  in  1  freeze stage (no accept, no release)
- drop_cnt  out  CNT_W  saturating count of valid entries discarded by flush
- occupancy  out  2  entries held (0..2)

Behaviour:
- Reset (async, any cycle, including mid-transfer):
  - state=EMPTY, out_valid=0, out_data=BUBBLE_DATA, drop_cnt=0, occupancy=0.
  - in_ready=1 (SKID_EN=1) or 1 (SKID_EN=0).
- Transfers:
  - accept = in_valid && in_ready && !stall && !flush.
  - release = out_valid && out_ready && !stall && !flush.
- States (SKID_EN=1): EMPTY (occ 0), MAIN (occ 1), SKID (occ 2). Main register drives out_data; the skid register holds overflow.
  - EMPTY: accept -> MAIN; in_data is presented next cycle, 1-cycle latency.
  - MAIN:
    - accept && release -> MAIN with the new data.
    - accept && !release -> SKID; in_data goes to the skid register.
    - release && !accept -> EMPTY.
  - SKID:
    - in_ready=0.
    - release -> MAIN; the skid entry moves to main the same edge.
    - no release -> hold.
- in_ready:
  - SKID_EN=1: registered; in_ready = (state != SKID), never depends on out_ready combinationally.
  - SKID_EN=0: states EMPTY/MAIN only; in_ready = (state==EMPTY) || out_ready, combinational.
- Stall:
  - All registers hold; in_ready forced 0; out_valid keeps its value; drop_cnt holds.
  - Data present before stall reappears unchanged after stall.
- Flush (priority over stall and handshake):
  - Next state EMPTY; both entries invalidated; out_data becomes BUBBLE_DATA next cycle.
  - in_data offered on a flush cycle is discarded (accept=0).
  - drop_cnt += occupancy (0, 1 or 2), saturating at 2^CNT_W-1 with no wrap.
- Priority: reset > flush > stall > handshake.
- Ordering: strict FIFO; the skid entry is never released before the main entry.
- occupancy is registered and mirrors state.
- No data is lost or duplicated under any out_ready pattern.

Decomposition:
- Shared package pipe_pkg:
  - enum skid_state_t {EMPTY, MAIN, SKID}.
  - INSTR_NOP = 32'h0000_0013 (addi x0,x0,0), used as the BUBBLE_DATA low word at IF/ID.
  - IFID_W = 64.
- One natural sub-module: sat_counter (parametrised width, increment-by-N, saturating), used for drop_cnt.

Test Plan:
- Streaming:
  - Stimulus: in_valid=1 with data 0x1..0x8 on consecutive cycles, out_ready=1.
  - Response: out_data 0x1..0x8 each one cycle later; in_ready stays 1; occupancy=1 throughout.
- Back-pressure:
  - Stimulus: send 0xA, 0xB with out_ready=0.
  - Response: occupancy=2, in_ready=0 the cycle after 0xB; on out_ready=1, outputs 0xA then 0xB, then in_ready=1.
- Flush with two entries held:
  - Stimulus: assert flush while 0xA, 0xB are held and in_data=0xC is valid.
  - Response: next cycle out_valid=0, out_data=BUBBLE_DATA, drop_cnt=2; 0xC is never output.
- Stall:
  - Stimulus: stall=1 for 3 cycles with out_ready=1 and in_valid=1, data 0x5 held in main.
  - Response: out_data stays 0x5, in_ready=0; 0x5 is released on the first cycle after stall drops.
- Saturation:
  - Stimulus: CNT_W=2, four flushes each with occupancy=1.
  - Response: drop_cnt is 1, 2, 3, 3.
- Async reset mid-transfer:
  - Stimulus: assert reset between clock edges with occupancy=2.
  - Response: out_valid=0, occupancy=0 and drop_cnt=0 immediately, without waiting for a clock edge.
- SKID_EN=0 variant:
  - Stimulus: repeat the back-pressure scenario.
  - Response: in_ready = out_ready while MAIN; occupancy never exceeds 1.

Source files
------------

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared types and constants for pipeline boundary stages.
//               Holds the skid-stage state encoding, the canonical NOP used
//               as the bubble word at IF/ID, and the IF/ID payload width.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // Stage fill state; the encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        MAIN  = 2'd1,
        SKID  = 2'd2
    } skid_state_t;

    // addi x0,x0,0 - low word of the bubble payload at IF/ID.
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    // IF/ID payload: {pc_plus_4, instr}.
    localparam int IFID_W = 64;

    // Number of entries held in a given state.
    function automatic logic [1:0] occ_of(input skid_state_t s);
        logic [1:0] occ;
        occ = 2'd0;
        case (s)
            MAIN:    occ = 2'd1;
            SKID:    occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Saturating up-counter that adds a variable increment when
//               enabled and sticks at all-ones instead of wrapping.
// Ports       : clk      - clock
//               rst      - asynchronous active-high reset (clears count)
//               i_en     - add i_inc this cycle
//               i_inc    - increment amount
//               o_count  - current count
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 16,
    parameter int INC_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [INC_W-1:0] i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_next;

    // One extra bit catches overflow; the increment never exceeds 2^WIDTH,
    // so a single carry bit is sufficient to detect saturation.
    always_comb begin
        w_sum  = {1'b0, r_count} + (WIDTH+1)'(i_inc);
        w_next = w_sum[WIDTH] ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= w_next;
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/pipe_skid_stage.sv
`default_nettype none
// ============================================================================
// Module      : pipe_skid_stage
// Description : Pipeline boundary register with valid/ready handshake and an
//               optional 2-entry skid buffer. Supports flush, stall and
//               back-pressure; drives a bubble word while empty and counts
//               valid entries squashed by flush.
// Ports       : clk, reset           - clock, async active-high reset
//               in_valid/in_data     - upstream payload
//               in_ready             - stage can accept this cycle
//               out_valid/out_data   - downstream payload (bubble when empty)
//               out_ready            - downstream accepts this cycle
//               flush                - squash all held entries
//               stall                - freeze stage
//               drop_cnt             - saturating count of flushed entries
//               occupancy            - entries held (0..2)
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int                DATA_W      = IFID_W,
    parameter logic [DATA_W-1:0] BUBBLE_DATA = '0,
    parameter int                SKID_EN     = 1,
    parameter int                CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    input  logic              flush,
    input  logic              stall,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic [1:0]        occupancy
);

    skid_state_t       r_state;
    skid_state_t       w_state_nxt;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;
    logic [1:0]        r_occ;

    logic w_in_ready_base;
    logic w_out_valid;
    logic w_accept;
    logic w_release;
    logic w_load_main_in;
    logic w_load_main_skid;
    logic w_load_skid;

    assign w_out_valid = (r_state != EMPTY);

    // ------------------------------------------------------------------
    // Ready generation. With the skid buffer the ready flag is a flop
    // computed from the next state, so out_ready never reaches in_ready
    // through logic. Without it, ready passes out_ready through while MAIN.
    // ------------------------------------------------------------------
    generate
        if (SKID_EN != 0) begin : g_skid_ready
            logic r_in_ready;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_in_ready <= 1'b1;
                end else begin
                    r_in_ready <= (w_state_nxt != SKID);
                end
            end
            assign w_in_ready_base = r_in_ready;
        end else begin : g_single_ready
            assign w_in_ready_base = (r_state == EMPTY) || out_ready;
        end
    endgenerate

    assign in_ready  = w_in_ready_base && !stall;

    assign w_accept  = in_valid && w_in_ready_base && !stall && !flush;
    assign w_release = w_out_valid && out_ready && !stall && !flush;

    // ------------------------------------------------------------------
    // Next-state and data-steering decode. Stall needs no explicit branch:
    // it already masks accept and release, so everything holds.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;

        if (flush) begin
            w_state_nxt = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt    = MAIN;
                        w_load_main_in = 1'b1;
                    end
                end
                MAIN: begin
                    if (w_accept && w_release) begin
                        w_load_main_in = 1'b1;
                    end else if (w_accept) begin
                        // Unreachable in single-entry mode: ready there
                        // implies out_ready, so an accept always releases.
                        if (SKID_EN != 0) begin
                            w_state_nxt = SKID;
                            w_load_skid = 1'b1;
                        end
                    end else if (w_release) begin
                        w_state_nxt = EMPTY;
                    end
                end
                SKID: begin
                    // Oldest entry sits in main; the skid entry slides
                    // forward on the same edge main is released.
                    if (w_release) begin
                        w_state_nxt      = MAIN;
                        w_load_main_skid = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= EMPTY;
            r_occ   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_occ   <= occ_of(w_state_nxt);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_main <= BUBBLE_DATA;
            r_skid <= BUBBLE_DATA;
        end else begin
            if (w_load_main_in) begin
                r_main <= in_data;
            end else if (w_load_main_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= in_data;
            end
        end
    end

    assign out_valid = w_out_valid;
    assign out_data  = w_out_valid ? r_main : BUBBLE_DATA;
    assign occupancy = r_occ;

    // Flush discards whatever is held; the registered occupancy is exactly
    // the number of valid entries lost on that edge.
    sat_counter #(
        .WIDTH (CNT_W),
        .INC_W (2)
    ) u_drop_cnt (
        .clk     (clk),
        .rst     (reset),
        .i_en    (flush),
        .i_inc   (r_occ),
        .o_count (drop_cnt)
    );

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_skid_stage
// Description : Self-checking bench for pipe_skid_stage. Three instances
//               share one stimulus: default skid stage, a 2-bit drop counter
//               variant and a single-entry (no skid) variant.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_skid_stage;
    import pipe_pkg::*;

    localparam logic [63:0] BUB = {32'h0, INSTR_NOP};

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [63:0] in_data;
    logic        out_ready;
    logic        flush;
    logic        stall;

    logic        d_in_ready, d_out_valid;
    logic [63:0] d_out_data;
    logic [15:0] d_drop;
    logic [1:0]  d_occ;

    logic        s_in_ready, s_out_valid;
    logic [63:0] s_out_data;
    logic [1:0]  s_drop;
    logic [1:0]  s_occ;

    logic        n_in_ready, n_out_valid;
    logic [63:0] n_out_data;
    logic [15:0] n_drop;
    logic [1:0]  n_occ;

    int          n_cmp;
    int          n_fail;
    logic        mon_en;
    logic [63:0] exp_q[$];
    logic [63:0] mon_exp;

    pipe_skid_stage #(.DATA_W(64), .BUBBLE_DATA(BUB), .SKID_EN(1), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(d_in_ready), .out_valid(d_out_valid), .out_data(d_out_data),
        .out_ready(out_ready), .flush(flush), .stall(stall),
        .drop_cnt(d_drop), .occupancy(d_occ)
    );

    pipe_skid_stage #(.DATA_W(64), .BUBBLE_DATA(BUB), .SKID_EN(1), .CNT_W(2)) dut_s (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(s_in_ready), .out_valid(s_out_valid), .out_data(s_out_data),
        .out_ready(out_ready), .flush(flush), .stall(stall),
        .drop_cnt(s_drop), .occupancy(s_occ)
    );

    pipe_skid_stage #(.DATA_W(64), .BUBBLE_DATA(BUB), .SKID_EN(0), .CNT_W(16)) dut_n (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(n_in_ready), .out_valid(n_out_valid), .out_data(n_out_data),
        .out_ready(out_ready), .flush(flush), .stall(stall),
        .drop_cnt(n_drop), .occupancy(n_occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Scoreboard: pop on every release of the main instance.
    always @(negedge clk) begin
        if (mon_en && !reset && d_out_valid && out_ready && !stall && !flush) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_extra: got %h, required no output", d_out_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (d_out_data !== mon_exp) begin
                    n_fail++;
                    $display("FAIL sb_data: got %h, required %h", d_out_data, mon_exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        stall     = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic check_drained(input string name);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d entries never output, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (d_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b, required 0", d_out_valid); end
        n_cmp++; if (d_out_data !== BUB) begin n_fail++; $display("FAIL rst_data: got %h, required %h", d_out_data, BUB); end
        n_cmp++; if (d_drop !== 16'd0) begin n_fail++; $display("FAIL rst_drop: got %0d, required 0", d_drop); end
        n_cmp++; if (d_occ !== 2'd0) begin n_fail++; $display("FAIL rst_occ: got %0d, required 0", d_occ); end
        n_cmp++; if (d_in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b, required 1", d_in_ready); end
        n_cmp++; if (n_in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready_noskid: got %b, required 1", n_in_ready); end
    endtask

    task automatic test_streaming();
        do_reset();
        mon_en    = 1'b1;
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = 64'(i);
            exp_q.push_back(64'(i));
            tick();
            n_cmp++; if (d_out_data !== 64'(i)) begin n_fail++; $display("FAIL stream_data: got %h, required %h", d_out_data, 64'(i)); end
            n_cmp++; if (d_in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready: got %b, required 1", d_in_ready); end
            n_cmp++; if (d_occ !== 2'd1) begin n_fail++; $display("FAIL stream_occ: got %0d, required 1", d_occ); end
        end
        in_valid = 1'b0;
        tick();
        n_cmp++; if (d_occ !== 2'd0) begin n_fail++; $display("FAIL stream_end_occ: got %0d, required 0", d_occ); end
        check_drained("stream");
    endtask

    task automatic test_backpressure();
        do_reset();
        mon_en    = 1'b1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'hA;
        exp_q.push_back(64'hA);
        tick();
        in_data = 64'hB;
        exp_q.push_back(64'hB);
        tick();
        in_valid = 1'b0;
        n_cmp++; if (d_occ !== 2'd2) begin n_fail++; $display("FAIL bp_occ: got %0d, required 2", d_occ); end
        n_cmp++; if (d_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready: got %b, required 0", d_in_ready); end
        n_cmp++; if (d_out_data !== 64'hA) begin n_fail++; $display("FAIL bp_head: got %h, required a", d_out_data); end
        out_ready = 1'b1;
        tick();
        n_cmp++; if (d_out_data !== 64'hB) begin n_fail++; $display("FAIL bp_second: got %h, required b", d_out_data); end
        n_cmp++; if (d_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_back: got %b, required 1", d_in_ready); end
        tick();
        n_cmp++; if (d_occ !== 2'd0) begin n_fail++; $display("FAIL bp_end_occ: got %0d, required 0", d_occ); end
        check_drained("bp");
    endtask

    task automatic test_flush();
        do_reset();
        mon_en    = 1'b1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'hA;
        tick();
        in_data = 64'hB;
        tick();
        flush   = 1'b1;
        in_data = 64'hC;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        n_cmp++; if (d_out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b, required 0", d_out_valid); end
        n_cmp++; if (d_out_data !== BUB) begin n_fail++; $display("FAIL flush_data: got %h, required %h", d_out_data, BUB); end
        n_cmp++; if (d_drop !== 16'd2) begin n_fail++; $display("FAIL flush_drop: got %0d, required 2", d_drop); end
        n_cmp++; if (d_occ !== 2'd0) begin n_fail++; $display("FAIL flush_occ: got %0d, required 0", d_occ); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (d_out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_leak: got valid %b data %h, required 0", d_out_valid, d_out_data); end
        end
        check_drained("flush");
    endtask

    task automatic test_stall();
        do_reset();
        mon_en    = 1'b1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'h5;
        exp_q.push_back(64'h5);
        tick();
        stall     = 1'b1;
        out_ready = 1'b1;
        in_data   = 64'h6;
        #1;
        n_cmp++; if (d_in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready: got %b, required 0", d_in_ready); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (d_out_data !== 64'h5) begin n_fail++; $display("FAIL stall_data: got %h, required 5", d_out_data); end
            n_cmp++; if (d_occ !== 2'd1) begin n_fail++; $display("FAIL stall_occ: got %0d, required 1", d_occ); end
        end
        stall    = 1'b0;
        in_valid = 1'b0;
        tick();
        n_cmp++; if (d_out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_release: got %b, required 0", d_out_valid); end
        check_drained("stall");
    endtask

    task automatic test_saturation();
        logic [1:0] exp_s;
        do_reset();
        mon_en    = 1'b0;
        out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            in_valid = 1'b1;
            in_data  = 64'(k);
            tick();
            in_valid = 1'b0;
            flush    = 1'b1;
            tick();
            flush = 1'b0;
            exp_s = (k > 3) ? 2'd3 : 2'(k);
            n_cmp++; if (s_drop !== exp_s) begin n_fail++; $display("FAIL sat_drop: got %0d, required %0d", s_drop, exp_s); end
            n_cmp++; if (d_drop !== 16'(k)) begin n_fail++; $display("FAIL wide_drop: got %0d, required %0d", d_drop, k); end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        mon_en    = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'h1;
        tick();
        in_valid = 1'b0;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b1;
        in_data  = 64'hA;
        tick();
        in_data = 64'hB;
        tick();
        in_valid = 1'b0;
        n_cmp++; if (d_occ !== 2'd2) begin n_fail++; $display("FAIL arst_pre_occ: got %0d, required 2", d_occ); end
        n_cmp++; if (d_drop !== 16'd1) begin n_fail++; $display("FAIL arst_pre_drop: got %0d, required 1", d_drop); end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if (d_out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %b, required 0", d_out_valid); end
        n_cmp++; if (d_occ !== 2'd0) begin n_fail++; $display("FAIL arst_occ: got %0d, required 0", d_occ); end
        n_cmp++; if (d_drop !== 16'd0) begin n_fail++; $display("FAIL arst_drop: got %0d, required 0", d_drop); end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_noskid();
        do_reset();
        mon_en    = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'hA;
        tick();
        n_cmp++; if (n_in_ready !== 1'b0) begin n_fail++; $display("FAIL ns_ready_main: got %b, required 0", n_in_ready); end
        n_cmp++; if (n_occ !== 2'd1) begin n_fail++; $display("FAIL ns_occ1: got %0d, required 1", n_occ); end
        in_data = 64'hB;
        tick();
        n_cmp++; if (n_occ !== 2'd1) begin n_fail++; $display("FAIL ns_occ_max: got %0d, required 1", n_occ); end
        n_cmp++; if (n_out_data !== 64'hA) begin n_fail++; $display("FAIL ns_head: got %h, required a", n_out_data); end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (n_in_ready !== 1'b1) begin n_fail++; $display("FAIL ns_ready_follow: got %b, required 1", n_in_ready); end
        tick();
        in_valid = 1'b0;
        n_cmp++; if (n_out_data !== 64'hB) begin n_fail++; $display("FAIL ns_second: got %h, required b", n_out_data); end
        n_cmp++; if (n_occ !== 2'd1) begin n_fail++; $display("FAIL ns_occ2: got %0d, required 1", n_occ); end
        tick();
        n_cmp++; if (n_occ !== 2'd0) begin n_fail++; $display("FAIL ns_end_occ: got %0d, required 0", n_occ); end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        mon_en = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_stall();
        test_saturation();
        test_async_reset();
        test_noskid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
